contador_param: RTL and testbench



---
 rtl/contador_param.sv | 84 ++++++++
 tb/tb_contador_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/contador_param.sv
// Parametrised multi-mode counter: up-by-STEP, down-by-1, up-by-1 and parallel load,
// with registered carry/borrow (rco) and load strobes aligned to the Q update.
module contador_param #(
  parameter int          WIDTH = 8,
  parameter int unsigned STEP  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             rco,
  output logic             load
);

  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_r;
  logic             rco_r;
  logic             load_r;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] q_next_s;
  logic             rco_next_s;
  logic             load_next_s;

  // Next-state selection; the extra sum bit carries the mode-00 wrap indication.
  always_comb begin
    sum_s       = {1'b0, q_r} + STEP_EXT;
    q_next_s    = q_r;
    rco_next_s  = 1'b0;
    load_next_s = 1'b0;
    if (enable) begin
      case (mode)
        2'b00: begin
          q_next_s   = sum_s[WIDTH-1:0];
          rco_next_s = sum_s[WIDTH];
        end
        2'b01: begin
          q_next_s   = q_r - ONE;
          rco_next_s = (q_r == ZERO);
        end
        2'b10: begin
          q_next_s   = q_r + ONE;
          rco_next_s = (q_r == ALL_ONES);
        end
        2'b11: begin
          q_next_s    = D;
          load_next_s = 1'b1;
        end
        default: begin
          q_next_s    = q_r;
          rco_next_s  = 1'b0;
          load_next_s = 1'b0;
        end
      endcase
    end else begin
      q_next_s    = q_r;
      rco_next_s  = 1'b0;
      load_next_s = 1'b0;
    end
  end

  // Count and strobe registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r    <= ZERO;
      rco_r  <= 1'b0;
      load_r <= 1'b0;
    end else begin
      q_r    <= q_next_s;
      rco_r  <= rco_next_s;
      load_r <= load_next_s;
    end
  end

  assign Q    = q_r;
  assign rco  = rco_r;
  assign load = load_r;

endmodule

// File: tb/tb_contador_param.sv
// Self-checking bench for contador_param: directed literal checks plus randomized
// stimulus compared every cycle against an arithmetic reference model (8/3 and 4/5 builds).
module tb_contador_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] d8 = 8'h00;
  logic [3:0] d4;
  logic [7:0] q8;
  logic [3:0] q4;
  logic       rco8, load8, rco4, load4;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  int mq8, mq4;
  bit mr8, ml8, mr4, ml4;

  assign d4 = d8[3:0];

  always #5 clk = ~clk;

  contador_param #(.WIDTH(8), .STEP(3)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(d8),
    .Q(q8), .rco(rco8), .load(load8)
  );

  contador_param #(.WIDTH(4), .STEP(5)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(d4),
    .Q(q4), .rco(rco4), .load(load4)
  );

  // Reference behaviour from the operation rules, using plain integer arithmetic.
  function automatic void mstep(input int w, input int stp, input int q, input bit en,
                                input logic [1:0] m, input int d,
                                output int nq, output bit nr, output bit nl);
    int lim;
    lim = 1 << w;
    nq = q; nr = 1'b0; nl = 1'b0;
    if (en) begin
      case (m)
        2'b00: begin nr = ((q + stp) >= lim); nq = (q + stp) % lim; end
        2'b01: begin nr = (q == 0); nq = (q + lim - 1) % lim; end
        2'b10: begin nr = (q == lim - 1); nq = (q + 1) % lim; end
        default: begin nq = d % lim; nl = 1'b1; end
      endcase
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    int t; bit r, l;
    if (!reset) begin
      mq8 <= 0; mr8 <= 1'b0; ml8 <= 1'b0;
      mq4 <= 0; mr4 <= 1'b0; ml4 <= 1'b0;
    end else begin
      mstep(8, 3, mq8, enable, mode, int'(d8), t, r, l);
      mq8 <= t; mr8 <= r; ml8 <= l;
      mstep(4, 5, mq4, enable, mode, int'(d4), t, r, l);
      mq4 <= t; mr4 <= r; ml4 <= l;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of both builds against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_q8", int'(q8), mq8);
      chk("model_rco8", int'(rco8), int'(mr8));
      chk("model_load8", int'(load8), int'(ml8));
      chk("model_q4", int'(q4), mq4);
      chk("model_rco4", int'(rco4), int'(mr4));
      chk("model_load4", int'(load4), int'(ml4));
      chk("excl8", int'(rco8 & load8), 0);
      chk("excl4", int'(rco4 & load4), 0);
    end
  end

  // Apply inputs at a negedge and advance through one rising edge.
  task automatic cyc(input bit en, input logic [1:0] m, input logic [7:0] d);
    enable = en; mode = m; d8 = d;
    @(negedge clk);
  endtask

  task automatic expect8(input string name, input int q, input int r, input int l);
    chk({name, "_q"}, int'(q8), q);
    chk({name, "_rco"}, int'(rco8), r);
    chk({name, "_load"}, int'(load8), l);
  endtask

  initial begin
    int hold;
    repeat (2) @(negedge clk);
    expect8("reset", 0, 0, 0);
    reset = 1'b1;
    chk_on = 1'b1;

    // Async reset mid-count
    repeat (8'h37) cyc(1'b1, 2'b10, 8'h00);
    expect8("count37", 8'h37, 0, 0);
    #2 reset = 1'b0;
    #1 expect8("async_rst", 0, 0, 0);
    @(negedge clk);
    expect8("rst_hold", 0, 0, 0);
    reset = 1'b1;

    // Load then step
    cyc(1'b1, 2'b11, 8'hFE); expect8("ld_fe", 8'hFE, 0, 1);
    cyc(1'b1, 2'b00, 8'h00); expect8("up3_wrap", 8'h01, 1, 0);
    cyc(1'b1, 2'b00, 8'h00); expect8("up3", 8'h04, 0, 0);

    // Down wrap
    cyc(1'b1, 2'b11, 8'h01);
    cyc(1'b1, 2'b01, 8'h00); expect8("dn0", 8'h00, 0, 0);
    cyc(1'b1, 2'b01, 8'h00); expect8("dn_wrap", 8'hFF, 1, 0);
    cyc(1'b1, 2'b01, 8'h00); expect8("dn_fe", 8'hFE, 0, 0);

    // Up-by-1 wrap and enable hold
    cyc(1'b1, 2'b11, 8'hFF);
    cyc(1'b1, 2'b10, 8'h00); expect8("up1_wrap", 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 2'(i), 8'h5A); expect8("hold", 8'h00, 0, 0);
    end

    // Mode switch every edge
    cyc(1'b1, 2'b11, 8'h10);
    cyc(1'b1, 2'b00, 8'h00); expect8("sw00", 8'h13, 0, 0);
    cyc(1'b1, 2'b01, 8'h00); expect8("sw01", 8'h12, 0, 0);
    cyc(1'b1, 2'b10, 8'h00); expect8("sw10", 8'h13, 0, 0);
    cyc(1'b1, 2'b11, 8'hA5); expect8("sw11", 8'hA5, 0, 1);
    cyc(1'b1, 2'b11, 8'hA5); expect8("ld_keep", 8'hA5, 0, 1);

    // WIDTH=4, STEP=5 sweep from zero
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    begin
      int exp_q[5] = '{5, 10, 15, 4, 9};
      int exp_r[5] = '{0, 0, 0, 1, 0};
      for (int i = 0; i < 5; i++) begin
        cyc(1'b1, 2'b00, 8'h00);
        chk("w4_q", int'(q4), exp_q[i]);
        chk("w4_rco", int'(rco4), exp_r[i]);
      end
    end

    // Randomized run with sporadic asynchronous reset pulses
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        #($urandom_range(1, 4)) reset = 1'b0;
        hold = $urandom_range(1, 3);
        repeat (hold) @(negedge clk);
        reset = 1'b1;
      end
      cyc(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 8'($urandom));
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
